// File: rtl/cv32e40p_ft_alu_reconf_ctrl_pkg.sv
// Shared types and constants for the fault-tolerant ALU reconfiguration controller.
package cv32e40p_ft_alu_reconf_ctrl_pkg;

  // Three voted slots backed by four physical ALUs; ALU3 is the spare.
  localparam int FT_ALU_NUM   = 4;
  localparam int FT_SLOT_NUM  = 3;
  localparam int FT_SPARE_IDX = 3;

  localparam logic [FT_SLOT_NUM-1:0] FT_SEL_PRIMARY = 3'b111;
  localparam logic [FT_ALU_NUM-1:0]  FT_CLK_EN_TMR  = 4'b0111;
  localparam logic [FT_ALU_NUM-1:0]  FT_CLK_EN_ALL  = 4'b1111;

  typedef enum logic [1:0] {
    NORMAL,
    SWAP_WAIT,
    SPARED,
    FAILED
  } ft_alu_reconf_state_e;

  // ALUs currently feeding a slot: ALU k when slot k selects it, the spare when any slot selects it.
  function automatic logic [FT_ALU_NUM-1:0] ft_in_use(input logic [FT_SLOT_NUM-1:0] sel);
    return {~&sel, sel};
  endfunction

endpackage

// File: rtl/cv32e40p_ft_leaky_err_cnt.sv
// One per-ALU leaky error counter: saturating increment, floored decrement, freeze, threshold flag.
module cv32e40p_ft_leaky_err_cnt #(
  parameter int CNT_W     = 5,
  parameter int THRESHOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             freeze_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             thr_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: an error beats a leak on the same cycle; a frozen counter holds its value.
  always_comb begin
    cnt_d = cnt_q;
    if (!freeze_i) begin
      if (inc_i) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else if (dec_i) begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign thr_o = (cnt_q >= CNT_THR);

endmodule

// File: rtl/cv32e40p_ft_alu_reconf_ctrl.sv
// Reconfiguration controller for the 4-replica ALU: attributes voter errors to physical ALUs,
// leaks and thresholds per-ALU error counts, and swaps the spare into a faulty slot.
module cv32e40p_ft_alu_reconf_ctrl
  import cv32e40p_ft_alu_reconf_ctrl_pkg::*;
#(
  parameter int CNT_W     = 5,
  parameter int THRESHOLD = 16,
  parameter int DECAY_OPS = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 op_valid_i,
  input  logic                                 ex_ready_i,
  input  logic [FT_SLOT_NUM-1:0]               slot_err_i,
  output logic [FT_SLOT_NUM-1:0]               sel_mux_o,
  output logic [FT_ALU_NUM-1:0]                clock_en_o,
  output logic [FT_ALU_NUM-1:0]                permanent_faulty_o,
  output logic [FT_ALU_NUM-1:0]                perf_fault_o,
  output logic [FT_ALU_NUM-1:0][CNT_W-1:0]     err_cnt_o,
  output logic                                 ft_fail_o
);

  localparam int                OPC_W   = (DECAY_OPS > 1) ? $clog2(DECAY_OPS) : 1;
  localparam logic [OPC_W-1:0]  OPC_MAX = OPC_W'(DECAY_OPS - 1);

  ft_alu_reconf_state_e state_q, state_d;
  logic [1:0]             swap_idx_q, swap_idx_d;
  logic [FT_SLOT_NUM-1:0] sel_q, sel_d;
  logic [FT_ALU_NUM-1:0]  clk_en_q, clk_en_d;
  logic [FT_ALU_NUM-1:0]  faulty_q, faulty_d;
  logic [FT_ALU_NUM-1:0]  perf_q, perf_d;
  logic                   ft_fail_q, ft_fail_d;
  logic [OPC_W-1:0]       op_cnt_q, op_cnt_d;

  logic [FT_ALU_NUM-1:0]  alu_inc;
  logic [FT_ALU_NUM-1:0]  alu_thr;
  logic [FT_ALU_NUM-1:0]  new_fault;
  logic                   any_new, multi_new;
  logic                   op_err, op_clean, decay;

  // Route each slot's voter error to the ALU currently driving that slot.
  always_comb begin
    alu_inc = '0;
    for (int k = 0; k < FT_SLOT_NUM; k++) begin
      if (op_valid_i && slot_err_i[k]) begin
        if (sel_q[k]) alu_inc[k]            = 1'b1;
        else          alu_inc[FT_SPARE_IDX] = 1'b1;
      end
    end
  end

  // Shared clean-op window: any error op restarts it, a full window triggers one leak step.
  always_comb begin
    op_err   = op_valid_i && (|slot_err_i);
    op_clean = op_valid_i && !(|slot_err_i);
    decay    = op_clean && (op_cnt_q == OPC_MAX);
    op_cnt_d = op_cnt_q;
    if (op_err)        op_cnt_d = '0;
    else if (decay)    op_cnt_d = '0;
    else if (op_clean) op_cnt_d = op_cnt_q + 1'b1;
  end

  for (genvar gi = 0; gi < FT_ALU_NUM; gi++) begin : g_err_cnt
    cv32e40p_ft_leaky_err_cnt #(
      .CNT_W     (CNT_W),
      .THRESHOLD (THRESHOLD)
    ) u_err_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc_i    (alu_inc[gi]),
      .dec_i    (decay),
      .freeze_i (faulty_q[gi]),
      .cnt_o    (err_cnt_o[gi]),
      .thr_o    (alu_thr[gi])
    );
  end

  // Fault declaration and next FSM state with the outputs that state implies.
  always_comb begin
    new_fault  = alu_thr & ~faulty_q;
    any_new    = |new_fault;
    multi_new  = |(new_fault & (new_fault - 1'b1));
    faulty_d   = faulty_q | alu_thr;
    perf_d     = new_fault;

    state_d    = state_q;
    swap_idx_d = swap_idx_q;
    sel_d      = sel_q;

    case (state_q)
      NORMAL: begin
        if (multi_new || new_fault[FT_SPARE_IDX]) begin
          state_d = FAILED;
        end else if (any_new) begin
          state_d = SWAP_WAIT;
          for (int k = 0; k < FT_SLOT_NUM; k++) begin
            if (new_fault[k]) swap_idx_d = 2'(k);
          end
        end
      end
      SWAP_WAIT: begin
        if (any_new) begin
          state_d = FAILED;
        end else if (ex_ready_i) begin
          state_d           = SPARED;
          sel_d[swap_idx_q] = 1'b0;
        end
      end
      SPARED: begin
        if (any_new) state_d = FAILED;
      end
      FAILED: begin
        state_d = FAILED;
      end
      default: begin
        state_d = FAILED;
      end
    endcase

    case (state_d)
      NORMAL:    clk_en_d = FT_CLK_EN_TMR;
      SWAP_WAIT: clk_en_d = FT_CLK_EN_ALL;
      SPARED:    clk_en_d = ~faulty_d;
      default:   clk_en_d = ft_in_use(sel_d) & ~faulty_d;
    endcase

    ft_fail_d = ft_fail_q | (state_d == FAILED);
  end

  // FSM and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= NORMAL;
      swap_idx_q <= '0;
      sel_q      <= FT_SEL_PRIMARY;
      clk_en_q   <= FT_CLK_EN_TMR;
      faulty_q   <= '0;
      perf_q     <= '0;
      ft_fail_q  <= 1'b0;
      op_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      swap_idx_q <= swap_idx_d;
      sel_q      <= sel_d;
      clk_en_q   <= clk_en_d;
      faulty_q   <= faulty_d;
      perf_q     <= perf_d;
      ft_fail_q  <= ft_fail_d;
      op_cnt_q   <= op_cnt_d;
    end
  end

  assign sel_mux_o          = sel_q;
  assign clock_en_o         = clk_en_q;
  assign permanent_faulty_o = faulty_q;
  assign perf_fault_o       = perf_q;
  assign ft_fail_o          = ft_fail_q;

endmodule

// File: tb/tb_cv32e40p_ft_alu_reconf_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_cv32e40p_ft_alu_reconf_ctrl;

  localparam int CNT_W     = 5;
  localparam int THRESHOLD = 16;
  localparam int DECAY_OPS = 64;
  localparam int CNT_SAT   = (1 << CNT_W) - 1;

  localparam int M_NORMAL  = 0;
  localparam int M_WAITING = 1;
  localparam int M_SPARED  = 2;
  localparam int M_FAILED  = 3;

  logic                  clk;
  logic                  rst;
  logic                  op_valid_i;
  logic                  ex_ready_i;
  logic [2:0]            slot_err_i;
  logic [2:0]            sel_mux_o;
  logic [3:0]            clock_en_o;
  logic [3:0]            permanent_faulty_o;
  logic [3:0]            perf_fault_o;
  logic [3:0][CNT_W-1:0] err_cnt_o;
  logic                  ft_fail_o;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model state
  int       m_cnt [4];
  bit       m_faulty [4];
  bit       m_perf [4];
  int       m_clean_ops;
  int       m_mode;
  int       m_pending;
  bit [2:0] m_sel;

  cv32e40p_ft_alu_reconf_ctrl #(
    .CNT_W     (CNT_W),
    .THRESHOLD (THRESHOLD),
    .DECAY_OPS (DECAY_OPS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .op_valid_i         (op_valid_i),
    .ex_ready_i         (ex_ready_i),
    .slot_err_i         (slot_err_i),
    .sel_mux_o          (sel_mux_o),
    .clock_en_o         (clock_en_o),
    .permanent_faulty_o (permanent_faulty_o),
    .perf_fault_o       (perf_fault_o),
    .err_cnt_o          (err_cnt_o),
    .ft_fail_o          (ft_fail_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]    = 0;
      m_faulty[i] = 1'b0;
      m_perf[i]   = 1'b0;
    end
    m_clean_ops = 0;
    m_mode      = M_NORMAL;
    m_pending   = 0;
    m_sel       = 3'b111;
  endtask

  // One clock of the reference behaviour, phrased from the controller's rules.
  task automatic model_step(input bit valid, input bit ready, input bit [2:0] err);
    bit crossed [4];
    bit hit [4];
    bit leak;
    int n_new;
    int idx;
    n_new = 0;
    idx   = 0;
    for (int i = 0; i < 4; i++) begin
      crossed[i] = !m_faulty[i] && (m_cnt[i] >= THRESHOLD);
      hit[i]     = 1'b0;
    end
    if (valid) begin
      for (int k = 0; k < 3; k++) begin
        if (err[k]) begin
          if (m_sel[k]) hit[k] = 1'b1;
          else          hit[3] = 1'b1;
        end
      end
    end
    leak = valid && (err == 3'b000) && (m_clean_ops + 1 == DECAY_OPS);
    for (int i = 0; i < 4; i++) begin
      if (!m_faulty[i]) begin
        if (hit[i])                      m_cnt[i] = (m_cnt[i] < CNT_SAT) ? m_cnt[i] + 1 : CNT_SAT;
        else if (leak && m_cnt[i] > 0)   m_cnt[i] = m_cnt[i] - 1;
      end
    end
    if (valid) begin
      if (err != 3'b000) m_clean_ops = 0;
      else               m_clean_ops = (m_clean_ops + 1) % DECAY_OPS;
    end
    for (int i = 0; i < 4; i++) begin
      m_perf[i] = crossed[i];
      if (crossed[i]) begin
        m_faulty[i] = 1'b1;
        n_new++;
        idx = i;
      end
    end
    if (m_mode == M_NORMAL) begin
      if (n_new >= 2 || crossed[3]) m_mode = M_FAILED;
      else if (n_new == 1) begin
        m_mode    = M_WAITING;
        m_pending = idx;
      end
    end else if (m_mode == M_WAITING) begin
      if (n_new > 0) m_mode = M_FAILED;
      else if (ready) begin
        m_sel[m_pending] = 1'b0;
        m_mode = M_SPARED;
      end
    end else if (m_mode == M_SPARED) begin
      if (n_new > 0) m_mode = M_FAILED;
    end
  endtask

  function automatic logic [3:0] model_faulty_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_faulty[i];
    return v;
  endfunction

  function automatic logic [3:0] model_perf_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_perf[i];
    return v;
  endfunction

  // Gated replicas: all four during the swap window, otherwise whichever healthy ALUs feed a slot.
  function automatic logic [3:0] model_clk_en();
    logic [3:0] in_use;
    in_use = {m_sel != 3'b111, m_sel};
    case (m_mode)
      M_NORMAL:  return 4'b0111;
      M_WAITING: return 4'b1111;
      M_SPARED:  return ~model_faulty_vec();
      default:   return in_use & ~model_faulty_vec();
    endcase
  endfunction

  task automatic check_all();
    check("sel_mux", 32'(sel_mux_o), 32'(m_sel));
    check("clock_en", 32'(clock_en_o), 32'(model_clk_en()));
    check("faulty", 32'(permanent_faulty_o), 32'(model_faulty_vec()));
    check("perf_fault", 32'(perf_fault_o), 32'(model_perf_vec()));
    check("ft_fail", 32'(ft_fail_o), 32'(m_mode == M_FAILED));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("err_cnt%0d", i), 32'(err_cnt_o[i]), 32'(m_cnt[i]));
    end
  endtask

  task automatic step(input bit valid, input bit ready, input bit [2:0] err);
    op_valid_i = valid;
    ex_ready_i = ready;
    slot_err_i = err;
    @(posedge clk);
    model_step(valid, ready, err);
    #1;
    check_all();
  endtask

  task automatic steps(input int n, input bit valid, input bit ready, input bit [2:0] err);
    for (int i = 0; i < n; i++) step(valid, ready, err);
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    op_valid_i = 1'b0;
    ex_ready_i = 1'b0;
    slot_err_i = 3'b000;
    @(posedge clk);
    model_reset();
    #1;
    check_all();
    check("rst_sel", 32'(sel_mux_o), 32'h7);
    check("rst_clk_en", 32'(clock_en_o), 32'h7);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    op_valid_i = 1'b0;
    ex_ready_i = 1'b0;
    slot_err_i = 3'b000;
    model_reset();

    // Clean traffic keeps TMR untouched
    apply_reset();
    for (int i = 0; i < 1000; i++) step(1'b1, 1'($urandom_range(0, 1)), 3'b000);
    check("clean_sel", 32'(sel_mux_o), 32'h7);
    check("clean_clk_en", 32'(clock_en_o), 32'h7);
    check("clean_cnt1", 32'(err_cnt_o[1]), 32'd0);
    check("clean_ft_fail", 32'(ft_fail_o), 32'd0);
    $display("scenario clean_ops done total=%0d bad=%0d", n_total, n_bad);

    // Slot1 crosses threshold with EX ready: one-cycle swap window
    apply_reset();
    steps(16, 1'b1, 1'b1, 3'b010);
    check("cross_cnt1", 32'(err_cnt_o[1]), 32'd16);
    step(1'b1, 1'b1, 3'b000);
    check("declare_faulty", 32'(permanent_faulty_o), 32'h2);
    check("declare_perf", 32'(perf_fault_o), 32'h2);
    check("declare_clk_en", 32'(clock_en_o), 32'hf);
    check("declare_sel", 32'(sel_mux_o), 32'h7);
    step(1'b1, 1'b1, 3'b000);
    check("swap_sel", 32'(sel_mux_o), 32'h5);
    check("swap_clk_en", 32'(clock_en_o), 32'hd);
    check("swap_perf", 32'(perf_fault_o), 32'h0);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, ($urandom_range(0, 19) == 0) ? 3'b001 : 3'b000);
    $display("scenario swap_ready done total=%0d bad=%0d", n_total, n_bad);

    // Slot1 crosses while EX stalls: swap waits for ex_ready_i
    apply_reset();
    steps(16, 1'b1, 1'b0, 3'b010);
    step(1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 3'b000);
      check("stall_sel", 32'(sel_mux_o), 32'h7);
      check("stall_clk_en", 32'(clock_en_o), 32'hf);
    end
    step(1'b0, 1'b1, 3'b000);
    check("late_swap_sel", 32'(sel_mux_o), 32'h5);
    $display("scenario swap_stall done total=%0d bad=%0d", n_total, n_bad);

    // Spared: slot1 errors now land on the spare, whose failure ends TMR
    steps(15, 1'b1, 1'b1, 3'b010);
    check("spare_cnt3", 32'(err_cnt_o[3]), 32'd15);
    check("spare_cnt1_frozen", 32'(err_cnt_o[1]), 32'd16);
    step(1'b1, 1'b1, 3'b010);
    step(1'b1, 1'b1, 3'b000);
    check("spare_fail_faulty", 32'(permanent_faulty_o), 32'ha);
    check("spare_fail_flag", 32'(ft_fail_o), 32'd1);
    check("spare_fail_sel", 32'(sel_mux_o), 32'h5);
    steps(3, 1'b1, 1'b1, 3'b000);
    $display("scenario spare_fail done total=%0d bad=%0d", n_total, n_bad);

    // Leaky decay and window restart
    apply_reset();
    steps(10, 1'b1, 1'b1, 3'b001);
    steps(64, 1'b1, 1'b1, 3'b000);
    check("decay_64", 32'(err_cnt_o[0]), 32'd9);
    steps(128, 1'b1, 1'b1, 3'b000);
    check("decay_192", 32'(err_cnt_o[0]), 32'd7);
    steps(30, 1'b1, 1'b1, 3'b000);
    step(1'b1, 1'b1, 3'b001);
    check("decay_err", 32'(err_cnt_o[0]), 32'd8);
    steps(63, 1'b1, 1'b1, 3'b000);
    check("decay_restart_hold", 32'(err_cnt_o[0]), 32'd8);
    step(1'b1, 1'b1, 3'b000);
    check("decay_restart_leak", 32'(err_cnt_o[0]), 32'd7);
    $display("scenario decay done total=%0d bad=%0d", n_total, n_bad);

    // Two slots cross together: straight to FAILED
    apply_reset();
    steps(16, 1'b1, 1'b1, 3'b101);
    step(1'b1, 1'b1, 3'b000);
    check("dual_faulty", 32'(permanent_faulty_o), 32'h5);
    check("dual_ft_fail", 32'(ft_fail_o), 32'd1);
    check("dual_sel", 32'(sel_mux_o), 32'h7);
    check("dual_clk_en", 32'(clock_en_o), 32'h2);
    steps(4, 1'b1, 1'b1, 3'b000);
    $display("scenario dual_fault done total=%0d bad=%0d", n_total, n_bad);

    // Reset in the middle of a pending swap
    apply_reset();
    steps(16, 1'b1, 1'b0, 3'b100);
    step(1'b1, 1'b0, 3'b000);
    check("pre_rst_clk_en", 32'(clock_en_o), 32'hf);
    apply_reset();
    check("post_rst_faulty", 32'(permanent_faulty_o), 32'h0);
    check("post_rst_cnt2", 32'(err_cnt_o[2]), 32'd0);
    steps(3, 1'b1, 1'b1, 3'b000);
    $display("scenario reset_mid_swap done total=%0d bad=%0d", n_total, n_bad);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit       v;
      bit       r;
      bit [2:0] e;
      if (i % 600 == 599) apply_reset();
      v = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 99) < 12) ? 3'($urandom_range(1, 7)) : 3'b000;
      step(v, r, e);
    end
    $display("scenario random done total=%0d bad=%0d", n_total, n_bad);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
